// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction at a time from the core, runs a
// single registered request/ack handshake with data memory, bounds the wait with a
// timeout counter, and reports completion with a one-cycle done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for op_valid; legal ops launch a request, illegal ones error
// ACCESS | mem_req held with stable address/data until ack or timeout
// DONE   | done pulse; held op_valid is the completing instruction, ignored
module load_store_unit #(
   parameter int BITS    = 16,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [BITS-1:0] addr,
   input  logic [BITS-1:0] storeData,
   output logic            mem_req,
   output logic            mem_we,
   output logic [BITS-1:0] mem_addr,
   output logic [BITS-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [BITS-1:0] mem_rdata,
   output logic [BITS-1:0] dataOut,
   output logic            stall,
   output logic            done,
   output logic            err,
   input  logic            err_clr
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [BITS-1:0] mem_addr_q, mem_addr_d;
   logic [BITS-1:0] mem_wdata_q, mem_wdata_d;
   logic [BITS-1:0] data_out_q, data_out_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [7:0]      wait_q, wait_d;
   logic [7:0]      wait_inc;
   logic            err_set;

   // Next-state and next-output computation for the access FSM.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      data_out_d  = data_out_q;
      wait_d      = wait_q;
      done_d      = 1'b0;
      err_set     = 1'b0;
      wait_inc    = wait_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               if (is_load ^ is_store) begin
                  mem_addr_d  = addr;
                  mem_wdata_d = storeData;
                  mem_we_d    = is_store;
                  mem_req_d   = 1'b1;
                  wait_d      = 8'd0;
                  state_d     = S_ACCESS;
               end else begin
                  err_set = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_ACCESS: begin
            // Ack is checked first so an ack on the final allowed cycle completes normally.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  data_out_d = mem_rdata;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (wait_inc == TIMEOUT_C) begin
               wait_d    = wait_inc;
               mem_req_d = 1'b0;
               err_set   = 1'b1;
               done_d    = 1'b1;
               state_d   = S_DONE;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State and registered outputs; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         data_out_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wait_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         data_out_q  <= data_out_d;
         done_q      <= done_d;
         err_q       <= err_d;
         wait_q      <= wait_d;
      end
   end

   // Stall is combinational; while rst is held the unit behaves as if in IDLE.
   always_comb begin
      if (rst) begin
         stall = op_valid;
      end else begin
         stall = (state_q == S_ACCESS) || ((state_q == S_IDLE) && op_valid);
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dataOut   = data_out_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions checked against a transaction-level model of the unit.
module tb_load_store_unit;

   localparam int BITS    = 16;
   localparam int TIMEOUT = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic            op_valid;
   logic            is_load;
   logic            is_store;
   logic [BITS-1:0] addr;
   logic [BITS-1:0] storeData;
   logic            mem_req;
   logic            mem_we;
   logic [BITS-1:0] mem_addr;
   logic [BITS-1:0] mem_wdata;
   logic            mem_ack;
   logic [BITS-1:0] mem_rdata;
   logic [BITS-1:0] dataOut;
   logic            stall;
   logic            done;
   logic            err;
   logic            err_clr;

   int              n_checks = 0;
   int              n_errors = 0;

   // model state: last loaded word and sticky error
   logic [BITS-1:0] exp_data;
   logic            exp_err;

   always #5 clk = ~clk;

   load_store_unit #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .is_load   (is_load),
      .is_store  (is_store),
      .addr      (addr),
      .storeData (storeData),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .dataOut   (dataOut),
      .stall     (stall),
      .done      (done),
      .err       (err),
      .err_clr   (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles with op_valid low; stray ack and opcode bits must be ignored.
   task automatic idle(input int n, input bit clr);
      op_valid = 1'b0;
      is_load  = 1'($urandom);
      is_store = 1'($urandom);
      mem_ack  = 1'($urandom);
      err_clr  = clr;
      for (int i = 0; i < n; i++) begin
         #1 chk("stall_idle_nop", 32'(stall), 32'(0));
         tick();
         if (clr) exp_err = 1'b0;
         chk("req_idle", 32'(mem_req), 32'(0));
         chk("done_idle", 32'(done), 32'(0));
         chk("err_idle", 32'(err), 32'(exp_err));
         chk("data_idle", 32'(dataOut), 32'(exp_data));
      end
      err_clr = 1'b0;
      mem_ack = 1'b0;
   endtask

   // One instruction: kind 0=load 1=store 2=both set 3=neither set.
   // lat = number of ACCESS cycles without ack before the ack cycle.
   // op_valid stays asserted through DONE, as the core would hold it.
   task automatic do_op(input int kind, input logic [BITS-1:0] a, input logic [BITS-1:0] d,
                        input logic [BITS-1:0] rd, input int lat, input bit clr);
      bit ld;
      bit st;
      int ncyc;
      ld = (kind == 0) || (kind == 2);
      st = (kind == 1) || (kind == 2);
      op_valid  = 1'b1;
      is_load   = ld;
      is_store  = st;
      addr      = a;
      storeData = d;
      mem_ack   = 1'b0;
      mem_rdata = ~rd;
      err_clr   = clr;
      #1 chk("stall_accept", 32'(stall), 32'(1));
      tick();
      err_clr = 1'b0;
      if (ld == st) begin
         exp_err = 1'b1;
         chk("req_illegal", 32'(mem_req), 32'(0));
         chk("done_illegal", 32'(done), 32'(1));
         chk("err_illegal", 32'(err), 32'(1));
         chk("stall_done", 32'(stall), 32'(0));
         chk("data_illegal", 32'(dataOut), 32'(exp_data));
      end else begin
         if (clr) exp_err = 1'b0;
         ncyc = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
         for (int k = 1; k <= ncyc; k++) begin
            chk("req_access", 32'(mem_req), 32'(1));
            chk("we_access", 32'(mem_we), 32'(st));
            chk("addr_access", 32'(mem_addr), 32'(a));
            chk("wdata_access", 32'(mem_wdata), 32'(d));
            chk("done_access", 32'(done), 32'(0));
            chk("err_access", 32'(err), 32'(exp_err));
            chk("stall_access", 32'(stall), 32'(1));
            chk("data_access", 32'(dataOut), 32'(exp_data));
            mem_ack   = (k == lat + 1);
            mem_rdata = (k == lat + 1) ? rd : BITS'($urandom);
            tick();
         end
         if (lat < TIMEOUT) begin
            if (ld) exp_data = rd;
         end else begin
            exp_err = 1'b1;
         end
         chk("req_done", 32'(mem_req), 32'(0));
         chk("done_pulse", 32'(done), 32'(1));
         chk("err_done", 32'(err), 32'(exp_err));
         chk("data_done", 32'(dataOut), 32'(exp_data));
         chk("stall_done", 32'(stall), 32'(0));
      end
      mem_ack   = 1'($urandom);
      mem_rdata = BITS'($urandom);
      tick();
      chk("done_once", 32'(done), 32'(0));
      chk("req_after", 32'(mem_req), 32'(0));
      chk("data_after", 32'(dataOut), 32'(exp_data));
      chk("err_after", 32'(err), 32'(exp_err));
      mem_ack = 1'b0;
   endtask

   task automatic reset_mid_access();
      op_valid  = 1'b1;
      is_load   = 1'b1;
      is_store  = 1'b0;
      addr      = 16'h0200;
      storeData = 16'h5555;
      mem_ack   = 1'b0;
      tick();
      chk("rma_req1", 32'(mem_req), 32'(1));
      tick();
      chk("rma_req2", 32'(mem_req), 32'(1));
      rst      = 1'b1;
      op_valid = 1'b0;
      #1 chk("stall_rst_nop", 32'(stall), 32'(0));
      op_valid = 1'b1;
      #1 chk("stall_rst_op", 32'(stall), 32'(1));
      op_valid = 1'b0;
      tick();
      rst       = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'hCAFE;
      exp_data  = '0;
      exp_err   = 1'b0;
      chk("rma_req", 32'(mem_req), 32'(0));
      chk("rma_we", 32'(mem_we), 32'(0));
      chk("rma_addr", 32'(mem_addr), 32'(0));
      chk("rma_wdata", 32'(mem_wdata), 32'(0));
      chk("rma_data", 32'(dataOut), 32'(0));
      chk("rma_done", 32'(done), 32'(0));
      chk("rma_err", 32'(err), 32'(0));
      #1 chk("rma_stall", 32'(stall), 32'(0));
      tick();
      chk("rma_late_req", 32'(mem_req), 32'(0));
      chk("rma_late_data", 32'(dataOut), 32'(0));
      chk("rma_late_done", 32'(done), 32'(0));
      mem_ack = 1'b0;
   endtask

   initial begin
      int r;
      int kind;
      int lat;
      rst       = 1'b1;
      op_valid  = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      addr      = '0;
      storeData = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      err_clr   = 1'b0;
      exp_data  = '0;
      exp_err   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_req", 32'(mem_req), 32'(0));
      chk("rst_we", 32'(mem_we), 32'(0));
      chk("rst_addr", 32'(mem_addr), 32'(0));
      chk("rst_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_data", 32'(dataOut), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_stall", 32'(stall), 32'(0));
      idle(2, 1'b0);

      // zero-wait load, then store with 3 waits presented straight after DONE
      do_op(0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1'b0);
      do_op(1, 16'h0100, 16'h1234, 16'h9999, 3, 1'b0);
      idle(1, 1'b0);
      // ack on the last allowed cycle wins; one more wait times out
      do_op(0, 16'h0300, 16'h0000, 16'hA5A5, TIMEOUT - 1, 1'b0);
      do_op(0, 16'h0304, 16'h0000, 16'h7777, TIMEOUT, 1'b0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      // illegal ops; err_clr in the same cycle as a new error loses
      do_op(2, 16'h0010, 16'h0020, 16'h0030, 0, 1'b0);
      idle(1, 1'b1);
      do_op(3, 16'h0011, 16'h0021, 16'h0031, 0, 1'b1);
      do_op(1, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1'b1);
      idle(1, 1'b0);
      reset_mid_access();

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         kind = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
         if ($urandom_range(0, 5) == 0) lat = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
         else lat = $urandom_range(0, 5);
         do_op(kind, BITS'($urandom), BITS'($urandom), BITS'($urandom), lat,
               $urandom_range(0, 7) == 0);
         r = $urandom_range(0, 2);
         if (r != 0) idle(r, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter BITS, default 16, giving the data and address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of ACCESS cycles allowed without mem_ack (range 1..255).
REQ-003 The block SHALL have these ports, one per entry below.
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  core presents a memory instruction this cycle
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- addr  in  BITS  effective address from the ALU
- storeData  in  BITS  register value to store
- mem_req  out  1  registered request to data memory
- mem_we  out  1  registered write enable (1 = store)
- mem_addr  out  BITS  registered memory address
- mem_wdata  out  BITS  registered store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  BITS  read data, valid when mem_ack = 1
- dataOut  out  BITS  last loaded word, registered; feeds the write-back bus select as its data source
- stall  out  1  combinational; core holds its current instruction while high
- done  out  1  one-cycle pulse marking completion of an operation
- err  out  1  sticky error flag
- err_clr  in  1  clears err

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-005 In IDLE with op_valid=1 and exactly one of is_load/is_store set, the block SHALL latch addr into mem_addr, storeData into mem_wdata and is_store into mem_we, set mem_req=1, and enter ACCESS at the next edge.
REQ-006 In IDLE with op_valid=1 and is_load=is_store, the block SHALL issue no memory request, set err=1 and enter DONE at the next edge.
REQ-007 In IDLE with op_valid=0, the block SHALL remain in IDLE with all registered outputs unchanged.
REQ-008 In ACCESS, mem_req SHALL stay 1 and mem_addr, mem_wdata and mem_we SHALL stay constant until mem_ack is sampled high.
REQ-009 In ACCESS with mem_ack=1, the block SHALL clear mem_req at that edge and enter DONE. On a load it SHALL also load mem_rdata into dataOut at that same edge.
REQ-010 On a store, dataOut SHALL be unchanged.
REQ-011 An 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without mem_ack.
REQ-012 When the wait counter reaches TIMEOUT with mem_ack=0, the block SHALL clear mem_req, set err=1, leave dataOut unchanged and enter DONE.
REQ-013 If mem_ack=1 arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: normal completion, no err.
REQ-014 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-015 In DONE, op_valid SHALL be ignored, because it is the completing instruction still held by the core.
REQ-016 stall SHALL be 1 in ACCESS, and 1 in IDLE when op_valid=1.
REQ-017 stall SHALL be 0 in DONE, and 0 in IDLE when op_valid=0.
REQ-018 The minimum latency SHALL be 3 cycles (accept, ACCESS with ack, DONE); each wait cycle adds one.
REQ-019 mem_ack SHALL be ignored outside ACCESS.
REQ-020 err SHALL stay set until rst, or until err_clr=1 is sampled.
REQ-021 If err_clr=1 and a new error event occur in the same cycle, err SHALL be set (the set wins).
REQ-022 All arithmetic SHALL be unsigned; addresses and data SHALL pass through unmodified at BITS width.

Reset
REQ-023 When rst=1 is sampled, the block SHALL go to IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, dataOut, done, err and the wait counter to 0.
REQ-024 During rst, stall SHALL follow REQ-016/REQ-017 for IDLE.
REQ-025 A rst during ACCESS SHALL drop mem_req at that edge and abandon the operation; a late mem_ack SHALL be ignored.
REQ-026 rst SHALL take priority over every other input.

Verification
REQ-027 Load, zero wait: op_valid=1, is_load=1, addr=0x0040; mem_ack=1 with mem_rdata=0xBEEF in the first ACCESS cycle -> mem_req high for 1 cycle, dataOut=0xBEEF, done pulse in cycle 3, stall high for cycles 1-2.
REQ-028 Store, 3 wait cycles: is_store=1, addr=0x0100, storeData=0x1234, ack on the 4th ACCESS cycle -> mem_we=1, mem_wdata=0x1234 stable throughout, dataOut unchanged, done in cycle 6.
REQ-029 Timeout: TIMEOUT=15, no ack -> mem_req drops after 15 ACCESS cycles, err=1, done pulse, dataOut unchanged; err_clr=1 then clears err.
REQ-030 Illegal operation: is_load=is_store=1 -> mem_req never asserted, err=1, done at cycle 2.
REQ-031 Reset mid-access: rst in the 2nd ACCESS cycle, then mem_ack=1 -> all outputs 0, state IDLE, dataOut stays 0.
REQ-032 Back-to-back: a load completes, op_valid is held through DONE, then a new store is presented in IDLE -> exactly one access per instruction and no duplicate request.
